instr_loader: RTL
=================

# instr_loader

Streams field-level instruction descriptions into the 9-bit instruction memory ahead of execution. Each accepted entry is packed into the opcode/field format read by the core's fetch/control path, then written to sequential IMEM addresses. It sits between the testbench/host program source and IMEM. The CPU is held off by `busy` until `done`.

## Interface
Parameters:
- `ADDR_W`, 10: IMEM address width. Capacity is 2^ADDR_W words.
- `BR_LUT_DEPTH`, 32: number of valid branch-target LUT entries. A BR target must be < this value.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; begins a load session at address 0
- `in_valid`  in  1  entry valid
- `in_ready`  out  1  loader can accept an entry
- `in_op`  in  3  opcode (AND 000, XOR 001, SHL 010, SHR 011, ADD 100, LW 101, SW 110, BR 111)
- `in_a`  in  3  field A (non-BR)
- `in_b`  in  3  field B (non-BR)
- `in_tgt`  in  6  branch LUT index (BR only)
- `in_last`  in  1  entry is the final one of the program
- `imem_we`  out  1  IMEM write strobe
- `imem_addr`  out  ADDR_W  IMEM write address
- `imem_wdata`  out  9  encoded instruction
- `busy`  out  1  session in progress
- `done`  out  1  session finished (level, held until next `start`)
- `err`  out  2  sticky: 00 none, 01 BR target out of range, 10 overflow
- `count`  out  ADDR_W+1  words written this session

## Operation
- Encoding is fixed:
  - Non-BR: `{op, a, b}`, i.e. [8:6] op, [5:3] A, [2:0] B.
  - BR: `{3'b111, tgt}`.
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE + `start`: go to LOAD. Clear `count`, address and `err`; drop `done`.
  - `start` in LOAD is ignored.
  - LOAD: an entry is accepted on a cycle with `in_valid && in_ready`.
  - `in_ready` = (state == LOAD).
- Accepted non-BR entry, or BR with `tgt` < BR_LUT_DEPTH:
  - written at the current address;
  - address and `count` increment.
- Accepted BR with `tgt` >= BR_LUT_DEPTH:
  - not written; address and `count` unchanged;
  - `err` = 01 unless already nonzero;
  - the session continues.
- Accepted entry with `in_last`: go to DONE after the write (or after the skip).
- Accepted written entry at address 2^ADDR_W−1 without `in_last`:
  - the word is written;
  - go to DONE with `err` = 10 (overflow overrides 01).
- Address never wraps.
- `busy` = (state == LOAD).

## Timing
- Reset values: state IDLE, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `busy` 0, `done` 0, `err` 00, `count` 0.
- `in_ready` is 0 during reset.
- `start` at edge N gives `busy`/`in_ready` = 1 from edge N.
- Write latency is 1 cycle. For an entry accepted at edge N:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered and valid after edge N, for one cycle only;
  - `count` updates at edge N.
- Back-to-back accepts produce consecutive write cycles; throughput is one word per clock.
- `done` rises at the edge accepting the last entry. The final `imem_we` pulse coincides with the first `done` cycle.
- Reset asserted mid-session:
  - all outputs return to reset values immediately (asynchronous);
  - a pending write is dropped;
  - IMEM contents are untouched.
- `in_valid` while not LOAD: ignored; no state change.

## Structure
- The Defs package gains:
  - `opcode_t` (moved from its local definition; the control decoder imports it from there);
  - `loader_state_t`;
  - `LD_ERR_NONE`/`LD_ERR_BR_RANGE`/`LD_ERR_OVF` constants.
- One combinational sub-module, `instr_encoder`:
  - inputs: op, a, b, tgt;
  - outputs: 9-bit word and `tgt_bad` (compares `tgt` against BR_LUT_DEPTH, passed in as a parameter).
- The FSM, counters and output registers live in `instr_loader`.

## Test plan
- **Basic load.** Reset, `start`, then ADD a=2 b=5 (last=0) and LW a=1 b=3 (last=1) on consecutive cycles.
  - Writes 9'h115 @0, then 9'h14B @1.
  - `done`=1, `count`=2, `err`=00.
- **Valid branch.** BR tgt=7, last=1 → 9'h1C7 written @0; `err`=00.
- **Out-of-range branch.** BR tgt=40 (BR_LUT_DEPTH=32), then XOR a=0 b=7 last.
  - No write for the BR.
  - 9'h047 written @0.
  - `count`=1, `err`=01.
- **Overflow.** With ADDR_W=2, stream 5 SW entries, none with last.
  - 4 writes @0..3.
  - DONE after the 4th; `err`=10; `in_ready`=0.
  - The 5th entry is never accepted.
- **Reset mid-load.** Assert `reset` the cycle after an accept.
  - `imem_we` drops immediately; all outputs at reset values.
  - A following `start` writes from address 0.
- **Gaps and ignored inputs.** Toggle `in_valid` with gaps; drive `in_valid` while in IDLE.
  - Writes occur only on handshake cycles.
  - Entries offered in IDLE produce no writes.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// ============================================================================
// Module   : instr_loader_pkg
// Purpose  : Shared opcode, loader state and loader error definitions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_XOR = 3'b001,
      OP_SHL = 3'b010,
      OP_SHR = 3'b011,
      OP_ADD = 3'b100,
      OP_LW  = 3'b101,
      OP_SW  = 3'b110,
      OP_BR  = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } loader_state_t;

   localparam logic [1:0] LD_ERR_NONE     = 2'b00;
   localparam logic [1:0] LD_ERR_BR_RANGE = 2'b01;
   localparam logic [1:0] LD_ERR_OVF      = 2'b10;

endpackage

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs one field-level entry into the 9-bit IMEM word format.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
   import instr_loader_pkg::*;
#(
   parameter int BR_LUT_DEPTH = 32
) (
   input  logic [2:0] i_op,
   input  logic [2:0] i_a,
   input  logic [2:0] i_b,
   input  logic [5:0] i_tgt,
   output logic [8:0] o_word,
   output logic       o_tgt_bad
);

   logic w_is_br;

   assign w_is_br = (opcode_t'(i_op) == OP_BR);

   always_comb begin
      o_word    = {i_op, i_a, i_b};
      o_tgt_bad = 1'b0;
      if (w_is_br) begin
         o_word    = {OP_BR, i_tgt};
         o_tgt_bad = ({26'd0, i_tgt} >= 32'(BR_LUT_DEPTH));
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module   : instr_loader
// Purpose  : Streams encoded instructions into sequential IMEM addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int BR_LUT_DEPTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [2:0]        in_a,
   input  logic [2:0]        in_b,
   input  logic [5:0]        in_tgt,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [8:0]        imem_wdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [ADDR_W:0]   count
);

   loader_state_t     r_state, w_state_nxt;
   logic [1:0]        r_err, w_err_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [8:0]        r_wdata;

   logic [8:0]        w_word;
   logic              w_tgt_bad;
   logic              w_accept;
   logic              w_write;
   logic              w_at_end;
   logic              w_start_ok;

   instr_encoder #(
      .BR_LUT_DEPTH (BR_LUT_DEPTH)
   ) u_encoder (
      .i_op      (in_op),
      .i_a       (in_a),
      .i_b       (in_b),
      .i_tgt     (in_tgt),
      .o_word    (w_word),
      .o_tgt_bad (w_tgt_bad)
   );

   assign w_accept   = in_valid && (r_state == ST_LOAD);
   assign w_write    = w_accept && !w_tgt_bad;
   assign w_at_end   = &r_addr;
   assign w_start_ok = start && (r_state != ST_LOAD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_err   <= LD_ERR_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt = ST_LOAD;
               w_err_nxt   = LD_ERR_NONE;
            end
         end
         ST_LOAD: begin
            if (w_accept) begin
               if (w_tgt_bad && (r_err == LD_ERR_NONE)) begin
                  w_err_nxt = LD_ERR_BR_RANGE;
               end
               // Filling the last word without a terminator is an overflow,
               // which outranks any earlier branch-range error.
               if (w_write && w_at_end && !in_last) begin
                  w_state_nxt = ST_DONE;
                  w_err_nxt   = LD_ERR_OVF;
               end else if (in_last) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_count <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_write;
         if (w_write) begin
            r_waddr <= r_addr;
            r_wdata <= w_word;
         end
         if (w_start_ok) begin
            r_addr  <= '0;
            r_count <= '0;
         end else if (w_write) begin
            r_count <= r_count + (ADDR_W + 1)'(1);
            if (!w_at_end) begin
               r_addr <= r_addr + ADDR_W'(1);
            end
         end
      end
   end

   assign in_ready   = (r_state == ST_LOAD);
   assign busy       = (r_state == ST_LOAD);
   assign done       = (r_state == ST_DONE);
   assign err        = r_err;
   assign count      = r_count;
   assign imem_we    = r_we;
   assign imem_addr  = r_waddr;
   assign imem_wdata = r_wdata;

endmodule

`default_nettype wire
